// File: rtl/commit_pkg.sv
// Shared types for the commit stage: destination kinds, FSM states, GPR indices
// and the EFLAGS reserved-bit mask.
package commit_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_REG  = 2'b01,
        KIND_MEM  = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM0,
        ST_MEM1,
        ST_RETIRE,
        ST_HALTED
    } state_e;

    typedef enum logic [2:0] {
        GPR_EAX = 3'd0,
        GPR_ECX = 3'd1,
        GPR_EDX = 3'd2,
        GPR_EBX = 3'd3,
        GPR_ESP = 3'd4,
        GPR_EBP = 3'd5,
        GPR_ESI = 3'd6,
        GPR_EDI = 3'd7
    } gpr_e;

    localparam logic [31:0] EFLAGS_RSVD1_MASK = 32'h0000_0002;

    // Everything execute hands over for one step, frozen at accept time.
    typedef struct packed {
        kind_e       kind0;
        kind_e       kind1;
        gpr_e        sel0;
        gpr_e        sel1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] opnd0;
        logic [31:0] opnd1;
        logic [31:0] eflags;
        logic [31:0] next_eip;
        logic        halt;
    } step_t;

    function automatic logic is_mem(input kind_e kind);
        return kind == KIND_MEM;
    endfunction

endpackage

// File: rtl/commit_gpr_file.sv
// 8x32 architectural register file with two write ports (port 1 wins on a
// same-index collision) and a flat 256-bit read-out.
module gpr_file
    import commit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we0,
    input  gpr_e         sel0,
    input  logic [31:0]  wd0,
    input  logic         we1,
    input  gpr_e         sel1,
    input  logic [31:0]  wd1,
    output logic [255:0] gpr_flat
);

    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];

    // NOTE: default copy first so every path assigns regs_d and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (we0) regs_d[sel0] = wd0;
        if (we1) regs_d[sel1] = wd1;
    end

    // NOTE: this array is architectural state that must read zero after reset,
    // so unlike a data RAM it is reset; non-blocking for all sequential state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        gpr_flat = '0;
        for (int i = 0; i < 8; i++) gpr_flat[32*i +: 32] = regs_q[i];
    end

endmodule

// File: rtl/commit.sv
// Commit stage: drains up to two memory writes, then retires a step atomically.
// Optional retired-step counter enabled by defining COMMIT_STEP_COUNT_EN.
module commit
    import commit_pkg::*;
#(
    parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
    parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  opnd0_w,
    input  logic [31:0]  opnd1_w,
    input  logic [31:0]  eflags_in,
    input  logic [31:0]  next_eip,
    input  logic [1:0]   dest0_kind,
    input  logic [1:0]   dest1_kind,
    input  logic [2:0]   dest0_sel,
    input  logic [2:0]   dest1_sel,
    input  logic [31:0]  dest0_addr,
    input  logic [31:0]  dest1_addr,
    input  logic         halt,
    output logic         mem_wr_valid,
    input  logic         mem_wr_ready,
    output logic [31:0]  mem_wr_addr,
    output logic [31:0]  mem_wr_data,
    output logic [255:0] gpr,
    output logic [31:0]  eip,
    output logic [31:0]  eflags,
    output logic         step_done,
    output logic         halted,
    output logic [31:0]  step_count
);

    state_e      state_q, state_d;
    step_t       step_q, step_d;
    logic [31:0] eip_q, eip_d;
    logic [31:0] eflags_q, eflags_d;
    logic        step_done_q, step_done_d;
    logic        retire;
    logic        we0, we1;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        eip_d        = eip_q;
        eflags_d     = eflags_q;
        step_done_d  = 1'b0;
        retire       = 1'b0;
        we0          = 1'b0;
        we1          = 1'b0;
        in_ready     = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = step_q.addr0;
        mem_wr_data  = step_q.opnd0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    step_d = '{kind0: kind_e'(dest0_kind), kind1: kind_e'(dest1_kind),
                               sel0: gpr_e'(dest0_sel), sel1: gpr_e'(dest1_sel),
                               addr0: dest0_addr, addr1: dest1_addr,
                               opnd0: opnd0_w, opnd1: opnd1_w,
                               eflags: eflags_in, next_eip: next_eip, halt: halt};
                    if (is_mem(kind_e'(dest0_kind)))      state_d = ST_MEM0;
                    else if (is_mem(kind_e'(dest1_kind))) state_d = ST_MEM1;
                    else                                  state_d = ST_RETIRE;
                end
            end
            ST_MEM0: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) state_d = is_mem(step_q.kind1) ? ST_MEM1 : ST_RETIRE;
            end
            ST_MEM1: begin
                mem_wr_valid = 1'b1;
                mem_wr_addr  = step_q.addr1;
                mem_wr_data  = step_q.opnd1;
                if (mem_wr_ready) state_d = ST_RETIRE;
            end
            ST_RETIRE: begin
                // Reserved kind falls through here as neither REG nor MEM.
                retire      = 1'b1;
                we0         = step_q.kind0 == KIND_REG;
                we1         = step_q.kind1 == KIND_REG;
                eip_d       = step_q.next_eip;
                eflags_d    = step_q.eflags | EFLAGS_RSVD1_MASK;
                step_done_d = 1'b1;
                state_d     = step_q.halt ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            eip_q       <= RESET_EIP;
            eflags_q    <= RESET_EFLAGS | EFLAGS_RSVD1_MASK;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            eip_q       <= eip_d;
            eflags_q    <= eflags_d;
            step_done_q <= step_done_d;
        end
    end

    gpr_file u_gpr_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .sel0     (step_q.sel0),
        .wd0      (step_q.opnd0),
        .we1      (we1),
        .sel1     (step_q.sel1),
        .wd1      (step_q.opnd1),
        .gpr_flat (gpr)
    );

`ifdef COMMIT_STEP_COUNT_EN
    logic [31:0] step_count_q, step_count_d;

    always_comb begin
        step_count_d = step_count_q;
        if (retire) step_count_d = step_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) step_count_q <= '0;
        else        step_count_q <= step_count_d;
    end

    assign step_count = step_count_q;
`else
    assign step_count = '0;
`endif

    assign eip       = eip_q;
    assign eflags    = eflags_q;
    assign step_done = step_done_q;
    assign halted    = state_q == ST_HALTED;

endmodule

// File: tb/tb_commit.sv
// Self-checking bench for commit: directed scenarios plus randomized steps
// compared against an array-based architectural model.
module tb_commit;

    localparam logic [31:0] R_EIP = 32'h0000_FFF0;
    localparam logic [31:0] R_EFL = 32'h0000_0200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  opnd0_w = '0, opnd1_w = '0, eflags_in = '0, next_eip = '0;
    logic [1:0]   dest0_kind = '0, dest1_kind = '0;
    logic [2:0]   dest0_sel = '0, dest1_sel = '0;
    logic [31:0]  dest0_addr = '0, dest1_addr = '0;
    logic         halt = 1'b0;
    logic         mem_wr_valid;
    logic         mem_wr_ready = 1'b0;
    logic [31:0]  mem_wr_addr, mem_wr_data;
    logic [255:0] gpr;
    logic [31:0]  eip, eflags;
    logic         step_done, halted;
    logic [31:0]  step_count;

    commit #(.RESET_EIP(R_EIP), .RESET_EFLAGS(R_EFL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .eflags_in(eflags_in), .next_eip(next_eip),
        .dest0_kind(dest0_kind), .dest1_kind(dest1_kind),
        .dest0_sel(dest0_sel), .dest1_sel(dest1_sel),
        .dest0_addr(dest0_addr), .dest1_addr(dest1_addr), .halt(halt),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .gpr(gpr), .eip(eip), .eflags(eflags), .step_done(step_done),
        .halted(halted), .step_count(step_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_gpr [8];
    logic [31:0] m_eip, m_efl, m_cnt;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = m_gpr[i];
        return f;
    endfunction

    task automatic check_arch(input string tag);
        logic [31:0] exp_cnt;
`ifdef COMMIT_STEP_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = '0;
`endif
        check({tag, "_gpr"}, gpr, model_flat());
        check({tag, "_eip"}, eip, m_eip);
        check({tag, "_eflags"}, eflags, m_efl);
        check({tag, "_count"}, step_count, exp_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_gpr[i] = '0;
        m_eip = R_EIP;
        m_efl = R_EFL | 32'h2;
        m_cnt = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        mem_wr_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic scramble_inputs();
        opnd0_w = $urandom; opnd1_w = $urandom; eflags_in = $urandom; next_eip = $urandom;
        dest0_addr = $urandom; dest1_addr = $urandom;
        dest0_kind = 2'($urandom); dest1_kind = 2'($urandom);
        dest0_sel = 3'($urandom); dest1_sel = 3'($urandom);
        halt = 1'($urandom);
    endtask

    // Runs one step starting and ending at a falling edge in the idle state.
    task automatic run_step(input string tag, input logic [1:0] k0, input logic [1:0] k1,
                            input logic [2:0] s0, input logic [2:0] s1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] o0, input logic [31:0] o1,
                            input logic [31:0] efl, input logic [31:0] neip,
                            input logic h, input int delay);
        logic [31:0] wa[$];
        logic [31:0] wd[$];
        check({tag, "_in_ready"}, in_ready, 1'b1);
        dest0_kind = k0; dest1_kind = k1; dest0_sel = s0; dest1_sel = s1;
        dest0_addr = a0; dest1_addr = a1; opnd0_w = o0; opnd1_w = o1;
        eflags_in = efl; next_eip = neip; halt = h; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        if (k0 == 2'b10) begin wa.push_back(a0); wd.push_back(o0); end
        if (k1 == 2'b10) begin wa.push_back(a1); wd.push_back(o1); end
        foreach (wa[w]) begin
            for (int c = 0; c <= delay; c++) begin
                check({tag, "_wr_valid"}, mem_wr_valid, 1'b1);
                check({tag, "_wr_addr"}, mem_wr_addr, wa[w]);
                check({tag, "_wr_data"}, mem_wr_data, wd[w]);
                check({tag, "_no_ready"}, in_ready, 1'b0);
                check_arch({tag, "_hold"});
                if (c < delay) begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            mem_wr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_wr_ready = 1'b0;
        end
        check({tag, "_ret_wr_valid"}, mem_wr_valid, 1'b0);
        check({tag, "_ret_done"}, step_done, 1'b0);
        check_arch({tag, "_pre"});
        if (k0 == 2'b01) m_gpr[s0] = o0;
        if (k1 == 2'b01) m_gpr[s1] = o1;
        m_eip = neip;
        m_efl = efl | 32'h2;
        m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, step_done, 1'b1);
        check_arch({tag, "_post"});
        check({tag, "_halted"}, halted, h);
        check({tag, "_ready_after"}, in_ready, !h);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, step_done, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();

        check_arch("reset");
        check("reset_wr_valid", mem_wr_valid, 1'b0);
        check("reset_done", step_done, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_ready", in_ready, 1'b1);

        run_step("add", 2'b01, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 32'd5, 32'h0,
                 32'h0000_0044, 32'h0000_1002, 1'b0, 0);
        check("add_eax", gpr[31:0], 32'd5);

        run_step("push", 2'b10, 2'b01, 3'd0, 3'd4, 32'h0000_0FFC, 32'h0, 32'h0000_00AB,
                 32'h0000_0FFC, 32'h0000_0001, 32'h0000_1003, 1'b0, 3);
        check("push_esp", gpr[159:128], 32'h0000_0FFC);

        run_step("same_sel", 2'b01, 2'b01, 3'd3, 3'd3, 32'h0, 32'h0, 32'd1, 32'd2,
                 32'h0000_0080, 32'h0000_1010, 1'b0, 0);
        check("same_sel_ebx", gpr[127:96], 32'd2);

        run_step("efl_zero", 2'b00, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h0000_2000, 1'b0, 0);
        check("efl_zero_val", eflags, 32'h0000_0002);

        run_step("mem_same", 2'b10, 2'b10, 3'd0, 3'd0, 32'h0000_0100, 32'h0000_0100,
                 32'h0000_0011, 32'h0000_0022, 32'h0, 32'h0000_2004, 1'b0, 1);

        run_step("rsvd", 2'b11, 2'b11, 3'd5, 3'd6, 32'h0, 32'h0, 32'hDEAD_BEEF,
                 32'hCAFE_F00D, 32'h0000_0400, 32'h0000_2008, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            run_step("rand", 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     1'b0, int'($urandom_range(0, 2)));
        end

        // Reset while the first memory write is still pending.
        dest0_kind = 2'b10; dest1_kind = 2'b01; dest0_addr = 32'h0000_0200;
        opnd0_w = 32'h55; dest1_sel = 3'd1; opnd1_w = 32'h66; next_eip = 32'h3000;
        halt = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mem_valid_before", mem_wr_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid_after", mem_wr_valid, 1'b0);
        rst_n = 1'b1;
        model_reset();
        check_arch("rst_mem");
        check("rst_mem_ready", in_ready, 1'b1);
        check("rst_mem_done", step_done, 1'b0);

        run_step("post_rst", 2'b01, 2'b00, 3'd7, 3'd0, 32'h0, 32'h0, 32'h0000_1234,
                 32'h0, 32'h0000_0001, 32'h0000_4000, 1'b0, 0);

        run_step("halt", 2'b01, 2'b00, 3'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0077,
                 32'h0, 32'h0000_0010, 32'h0000_5000, 1'b1, 0);
        dest0_kind = 2'b01; dest0_sel = 3'd2; opnd0_w = 32'h0000_9999;
        dest1_kind = 2'b00; next_eip = 32'h0000_6000; halt = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("halted_sticky", halted, 1'b1);
            check("halted_ready", in_ready, 1'b0);
            check("halted_done", step_done, 1'b0);
            check("halted_wr_valid", mem_wr_valid, 1'b0);
            check_arch("halted");
        end
        in_valid = 1'b0;
        do_reset();
        check("unhalt_halted", halted, 1'b0);
        check("unhalt_ready", in_ready, 1'b1);
        check_arch("unhalt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit.md
COMMIT -- requirements
Module: commit

Interface
REQ-001 Parameter RESET_EIP, default 32'h0000_0000, EIP value loaded on reset.
REQ-002 Parameter RESET_EFLAGS, default 32'h0000_0002, EFLAGS value loaded on reset; bit 1 always reads 1.
REQ-003 The ports SHALL be:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  execute results valid.
- in_ready  out  1  commit can accept a step.
- opnd0_w, opnd1_w  in  32  each  execute write operands.
- eflags_in  in  32  execute's o_eflags.
- next_eip  in  32  execute's next EIP.
- dest0_kind, dest1_kind  in  2  each  00 NONE, 01 REG, 10 MEM, 11 reserved.
- dest0_sel, dest1_sel  in  3  each  GPR index (EAX=0 .. EDI=7).
- dest0_addr, dest1_addr  in  32  each  memory address.
- halt  in  1  step is HLT; sampled with in_valid.
- mem_wr_valid  out  1  memory write request.
- mem_wr_ready  in  1  memory accepts the request.
- mem_wr_addr, mem_wr_data  out  32  each  write address and data.
- gpr  out  256  architectural GPRs, GPR i at [32i+31:32i].
- eip, eflags  out  32  each  architectural EIP and EFLAGS.
- step_done  out  1  one-cycle pulse per retired step.
- halted  out  1  machine halted.
- step_count  out  32  retired-step counter.

Function
REQ-004 States SHALL be IDLE, MEM0, MEM1, RETIRE, HALTED.
REQ-005 in_ready SHALL be 1 only in IDLE; a step is accepted when in_valid && in_ready, and all inputs are captured that cycle.
REQ-006 After an accept, the next state SHALL be MEM0 if dest0_kind=MEM, else MEM1 if dest1_kind=MEM, else RETIRE.
REQ-007 In MEM0, mem_wr_valid=1, addr=dest0_addr, data=opnd0_w; on mem_wr_ready go to MEM1 if dest1 is MEM, else RETIRE. MEM1 behaves the same with dest1/opnd1_w.
REQ-008 mem_wr_valid, mem_wr_addr and mem_wr_data SHALL stay stable until the handshake completes; mem_wr_valid SHALL be 0 outside MEM0/MEM1.
REQ-009 RETIRE SHALL write every REG destination to gpr, load eip<=next_eip and eflags<=eflags_in with bit 1 forced to 1, and pulse step_done.
REQ-010 If both destinations are REG with the same sel, dest1 SHALL win.
REQ-011 Reserved kind 11 SHALL be treated as NONE.
REQ-012 Latency for no-MEM steps: accept at cycle T, RETIRE at T+1, updated outputs and in_ready=1 at T+2; each MEM write adds at least one cycle.
REQ-013 Two MEM writes to the same address SHALL be issued in order: dest0, then dest1.
REQ-014 From RETIRE, the next state SHALL be HALTED if the captured halt=1, else IDLE. HALTED is sticky until reset: in_ready=0 and halted=1.
REQ-015 Architectural state (gpr, eip, eflags) SHALL change only in RETIRE, so a step commits atomically.

Reset
REQ-016 While rst_n=0 at a clock edge: state<=IDLE, gpr<=0, eip<=RESET_EIP, eflags<=RESET_EFLAGS|2, step_count<=0. All outputs are inactive: mem_wr_valid=0, step_done=0, halted=0.
REQ-017 Reset during MEM0/MEM1 SHALL drop mem_wr_valid on the following cycle and abandon the step with no architectural update.

Configuration
REQ-018 Macro COMMIT_STEP_COUNT_EN defined: step_count increments by 1 in each RETIRE and wraps from 32'hFFFF_FFFF to 0.
REQ-019 Macro not defined: the step_count port still exists, is tied to 0, and no counter register is built.

Structure
REQ-020 Package commit_pkg SHALL hold the dest-kind encodings, the state enum, the GPR index constants and the EFLAGS reserved-bit-1 mask.
REQ-021 Sub-module gpr_file SHALL be an 8x32 register file with two write ports (port 1 has priority) and a flat read output.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD-like step: dest0 REG sel=0, opnd0_w=5, next_eip=0x1002, no MEM -> at T+2 EAX=5, eip=0x1002, one step_done pulse.
- PUSH-like step: dest0 MEM addr=0xFFC data=0xAB, dest1 REG sel=4 opnd1_w=0xFFC, mem_wr_ready low 3 cycles -> request held stable 4 cycles; ESP=0xFFC only after the handshake.
- Both dest REG sel=3, opnd0_w=1, opnd1_w=2 -> EBX=2.
- eflags_in=0 -> eflags reads 0x2.
- halt=1 step -> retires, then halted=1 and in_ready=0; the next in_valid is ignored until rst_n pulse.
- rst_n low during MEM0 -> mem_wr_valid=0 the next cycle, eip=RESET_EIP, step_count=0.
